// File: rtl/layer1_ctrl.sv
// Sequencer for a 2x2 dense layer: loads weights, seeds the accumulators,
// then runs a programmed number of start/wait passes with a per-pass timeout.
module layer1_ctrl #(
   parameter int LOAD_CYCLES = 1,
   parameter int TIMEOUT     = 64,
   parameter int PASS_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic                abort,
   input  logic [PASS_W-1:0]   num_passes,
   input  logic signed [15:0]  x1_in,
   input  logic signed [15:0]  x2_in,
   input  logic                lr_valid_21,
   input  logic                lr_valid_22,
   output logic                load_weights,
   output logic                start,
   output logic signed [15:0]  acc_data_nn_in1,
   output logic                acc_valid_data_nn_in1,
   output logic signed [15:0]  acc_data_nn_in2,
   output logic                acc_valid_data_nn_in2,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [PASS_W-1:0]   pass_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PRELOAD, S_START, S_WAIT, S_DONE, S_ERR
   } state_t;

   localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [3:0]           load_cnt_q, load_cnt_d;
   logic [7:0]           tmo_cnt_q, tmo_cnt_d;
   logic                 seen1_q, seen1_d;
   logic                 seen2_q, seen2_d;
   logic [PASS_W-1:0]    num_passes_q, num_passes_d;
   logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
   logic signed [15:0]   x1_q, x1_d;
   logic signed [15:0]   x2_q, x2_d;

   logic                 load_weights_q, load_weights_d;
   logic                 start_q, start_d;
   logic                 nn_valid_q, nn_valid_d;
   logic signed [15:0]   nn_data1_q, nn_data1_d;
   logic signed [15:0]   nn_data2_q, nn_data2_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   always_comb begin
      state_d      = state_q;
      load_cnt_d   = load_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      seen1_d      = seen1_q;
      seen2_d      = seen2_q;
      num_passes_d = num_passes_q;
      pass_cnt_d   = pass_cnt_q;
      x1_d         = x1_q;
      x2_d         = x2_q;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  if (num_passes != '0) begin
                     num_passes_d = num_passes;
                     x1_d         = x1_in;
                     x2_d         = x2_in;
                     pass_cnt_d   = '0;
                     load_cnt_d   = '0;
                     state_d      = S_LOAD;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_LOAD: begin
               if (load_cnt_q == LOAD_LAST) state_d = S_PRELOAD;
               else                         load_cnt_d = load_cnt_q + 4'd1;
            end
            S_PRELOAD: state_d = S_START;
            S_START: begin
               seen1_d   = 1'b0;
               seen2_d   = 1'b0;
               tmo_cnt_d = '0;
               state_d   = S_WAIT;
            end
            // A valid arriving in the final timeout cycle still completes the pass.
            S_WAIT: begin
               seen1_d = seen1_q | lr_valid_21;
               seen2_d = seen2_q | lr_valid_22;
               if (seen1_d && seen2_d) begin
                  pass_cnt_d = pass_cnt_q + 1'b1;
                  state_d    = (pass_cnt_d == num_passes_q) ? S_DONE : S_START;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  state_d = S_ERR;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 8'd1;
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
      end

      load_weights_d = (state_d == S_LOAD);
      start_d        = (state_d == S_START);
      nn_valid_d     = (state_d == S_PRELOAD);
      nn_data1_d     = (state_d == S_PRELOAD) ? x1_q : 16'sd0;
      nn_data2_d     = (state_d == S_PRELOAD) ? x2_q : 16'sd0;
      busy_d         = (state_d != S_IDLE) && (state_d != S_ERR);
      done_d         = (state_d == S_DONE);
      err_d          = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         load_cnt_q     <= '0;
         tmo_cnt_q      <= '0;
         seen1_q        <= 1'b0;
         seen2_q        <= 1'b0;
         num_passes_q   <= '0;
         pass_cnt_q     <= '0;
         x1_q           <= '0;
         x2_q           <= '0;
         load_weights_q <= 1'b0;
         start_q        <= 1'b0;
         nn_valid_q     <= 1'b0;
         nn_data1_q     <= '0;
         nn_data2_q     <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_cnt_q     <= load_cnt_d;
         tmo_cnt_q      <= tmo_cnt_d;
         seen1_q        <= seen1_d;
         seen2_q        <= seen2_d;
         num_passes_q   <= num_passes_d;
         pass_cnt_q     <= pass_cnt_d;
         x1_q           <= x1_d;
         x2_q           <= x2_d;
         load_weights_q <= load_weights_d;
         start_q        <= start_d;
         nn_valid_q     <= nn_valid_d;
         nn_data1_q     <= nn_data1_d;
         nn_data2_q     <= nn_data2_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_q          <= err_d;
      end
   end

   assign load_weights          = load_weights_q;
   assign start                 = start_q;
   assign acc_valid_data_nn_in1 = nn_valid_q;
   assign acc_valid_data_nn_in2 = nn_valid_q;
   assign acc_data_nn_in1       = nn_data1_q;
   assign acc_data_nn_in2       = nn_data2_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign timeout_err           = err_q;
   assign pass_cnt              = pass_cnt_q;

endmodule

// File: tb/tb_layer1_ctrl.sv
// Self-checking bench for layer1_ctrl: scoreboard queues for preload data and
// done events, plus cycle-accurate checks of the sequencing outputs.
module tb_layer1_ctrl;

   logic               clk;
   logic               rst;
   logic               go;
   logic               abort;
   logic [3:0]         num_passes;
   logic signed [15:0] x1_in;
   logic signed [15:0] x2_in;
   logic               lr_valid_21;
   logic               lr_valid_22;
   logic               load_weights;
   logic               start;
   logic signed [15:0] acc_data_nn_in1;
   logic               acc_valid_data_nn_in1;
   logic signed [15:0] acc_data_nn_in2;
   logic               acc_valid_data_nn_in2;
   logic               busy;
   logic               done;
   logic               timeout_err;
   logic [3:0]         pass_cnt;

   int compareCount  = 0;
   int mismatchCount = 0;
   int startCount    = 0;
   int preloadCount  = 0;
   int doneCount     = 0;

   logic [31:0] nnQ[$];
   logic [3:0]  doneQ[$];

   layer1_ctrl #(.LOAD_CYCLES(1), .TIMEOUT(64), .PASS_W(4)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .go                    (go),
      .abort                 (abort),
      .num_passes            (num_passes),
      .x1_in                 (x1_in),
      .x2_in                 (x2_in),
      .lr_valid_21           (lr_valid_21),
      .lr_valid_22           (lr_valid_22),
      .load_weights          (load_weights),
      .start                 (start),
      .acc_data_nn_in1       (acc_data_nn_in1),
      .acc_valid_data_nn_in1 (acc_valid_data_nn_in1),
      .acc_data_nn_in2       (acc_data_nn_in2),
      .acc_valid_data_nn_in2 (acc_valid_data_nn_in2),
      .busy                  (busy),
      .done                  (done),
      .timeout_err           (timeout_err),
      .pass_cnt              (pass_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive an accepted go for one cycle, recording what the DUT owes us.
   task automatic applyStimulus(input logic [3:0] n, input logic [15:0] a, input logic [15:0] b, input bit expectRun);
      num_passes = n;
      x1_in      = a;
      x2_in      = b;
      go         = 1'b1;
      if (expectRun) begin
         if (n != 0) nnQ.push_back({a, b});
         doneQ.push_back(n);
      end
      stepCycle();
      go = 1'b0;
   endtask

   task automatic waitStart(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (start) break;
         stepCycle();
      end
      checkOutput("start_seen", 32'(start), 32'd1);
   endtask

   // Called in the START cycle; d1/d2 are the WAIT cycles carrying each valid, dup adds an extra lr_valid_21.
   task automatic respond(input int d1, input int d2, input int dup);
      int last;
      last = (d1 > d2) ? d1 : d2;
      for (int i = 1; i <= last; i++) begin
         stepCycle();
         lr_valid_21 = (i == d1) || (i == dup);
         lr_valid_22 = (i == d2);
      end
      stepCycle();
      lr_valid_21 = 1'b0;
      lr_valid_22 = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (start) startCount++;
         if (acc_valid_data_nn_in1 || acc_valid_data_nn_in2) begin
            logic [31:0] exp;
            preloadCount++;
            if (nnQ.size() == 0) begin
               checkOutput("nn_unexpected", 32'({acc_valid_data_nn_in1, acc_valid_data_nn_in2}), 32'd0);
            end else begin
               exp = nnQ.pop_front();
               checkOutput("nn_valid_pair", 32'({acc_valid_data_nn_in1, acc_valid_data_nn_in2}), 32'd3);
               checkOutput("nn_data1", 32'(acc_data_nn_in1), 32'($signed(exp[31:16])));
               checkOutput("nn_data2", 32'(acc_data_nn_in2), 32'($signed(exp[15:0])));
            end
         end
         if (done) begin
            doneCount++;
            if (doneQ.size() == 0) checkOutput("done_unexpected", 32'(done), 32'd0);
            else                   checkOutput("done_pass_cnt", 32'(pass_cnt), 32'(doneQ.pop_front()));
         end
      end
   end

   initial begin
      int errCycles;
      rst = 1'b1;
      go = 1'b0; abort = 1'b0; num_passes = '0; x1_in = '0; x2_in = '0;
      lr_valid_21 = 1'b0; lr_valid_22 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", 32'({load_weights, start, acc_valid_data_nn_in1, acc_valid_data_nn_in2,
                  busy, done, timeout_err, pass_cnt}), 32'd0);
      checkOutput("reset_data", {acc_data_nn_in1, acc_data_nn_in2}, 32'd0);
      rst = 1'b0;
      stepCycle();

      $display("[TB] single pass");
      applyStimulus(4'd1, 16'h0100, 16'h0200, 1'b1);
      checkOutput("c1_load_weights", 32'(load_weights), 32'd1);
      checkOutput("c1_busy", 32'(busy), 32'd1);
      stepCycle();
      checkOutput("c2_load_weights", 32'(load_weights), 32'd0);
      checkOutput("c2_nn_valid", 32'(acc_valid_data_nn_in1), 32'd1);
      stepCycle();
      checkOutput("c3_start", 32'(start), 32'd1);
      checkOutput("c3_nn_data_zero", {acc_data_nn_in1, acc_data_nn_in2}, 32'd0);
      respond(4, 4, 0);
      checkOutput("c8_done", 32'(done), 32'd1);
      stepCycle();
      checkOutput("c9_busy", 32'(busy), 32'd0);
      checkOutput("c9_pass_cnt", 32'(pass_cnt), 32'd1);

      $display("[TB] three passes with go while busy");
      startCount = 0; preloadCount = 0; doneCount = 0;
      applyStimulus(4'd3, 16'h0011, -16'sd5, 1'b1);
      waitStart(10);
      respond(2, 3, 0);
      checkOutput("p2_start", 32'(start), 32'd1);
      num_passes = 4'd7; x1_in = 16'h7777; x2_in = 16'h6666; go = 1'b1;
      respond(1, 1, 0);
      go = 1'b0;
      checkOutput("p3_start", 32'(start), 32'd1);
      checkOutput("p3_pass_cnt", 32'(pass_cnt), 32'd2);
      respond(3, 2, 0);
      checkOutput("p3_done", 32'(done), 32'd1);
      stepCycle();
      checkOutput("p_start_count", 32'(startCount), 32'd3);
      checkOutput("p_preload_count", 32'(preloadCount), 32'd1);
      checkOutput("p_done_count", 32'(doneCount), 32'd1);
      checkOutput("p_final_pass_cnt", 32'(pass_cnt), 32'd3);

      $display("[TB] skewed and duplicate valids");
      applyStimulus(4'd2, 16'h0042, 16'h0043, 1'b1);
      waitStart(10);
      respond(2, 5, 3);
      checkOutput("skew_no_done", 32'(done), 32'd0);
      checkOutput("skew_pass_cnt", 32'(pass_cnt), 32'd1);
      checkOutput("skew_restart", 32'(start), 32'd1);
      respond(1, 1, 0);
      checkOutput("skew_done", 32'(done), 32'd1);
      stepCycle();

      $display("[TB] timeout");
      applyStimulus(4'd2, 16'h0001, 16'h0002, 1'b0);
      nnQ.push_back({16'h0001, 16'h0002});
      waitStart(10);
      errCycles = 0;
      while (!timeout_err && errCycles < 100) begin
         stepCycle();
         errCycles++;
      end
      checkOutput("tmo_cycles", 32'(errCycles), 32'd65);
      repeat (3) stepCycle();
      lr_valid_21 = 1'b1; lr_valid_22 = 1'b1;
      stepCycle();
      lr_valid_21 = 1'b0; lr_valid_22 = 1'b0;
      checkOutput("tmo_err_held", 32'(timeout_err), 32'd1);
      checkOutput("tmo_busy", 32'(busy), 32'd0);
      checkOutput("tmo_pass_cnt", 32'(pass_cnt), 32'd0);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("abort_err_clear", 32'(timeout_err), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);

      $display("[TB] zero passes");
      startCount = 0;
      applyStimulus(4'd0, 16'h1234, 16'h5678, 1'b1);
      checkOutput("zero_done", 32'(done), 32'd1);
      checkOutput("zero_no_load", 32'(load_weights), 32'd0);
      stepCycle();
      checkOutput("zero_no_start", 32'(startCount), 32'd0);
      checkOutput("zero_idle", 32'(busy), 32'd0);

      $display("[TB] abort during load");
      applyStimulus(4'd1, 16'h0AAA, 16'h0BBB, 1'b0);
      checkOutput("ab_load_before", 32'(load_weights), 32'd1);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      checkOutput("ab_load_dropped", 32'(load_weights), 32'd0);
      checkOutput("ab_busy", 32'(busy), 32'd0);
      stepCycle();

      $display("[TB] async reset mid-wait");
      applyStimulus(4'd1, 16'h0055, 16'h0066, 1'b0);
      nnQ.push_back({16'h0055, 16'h0066});
      waitStart(10);
      repeat (2) stepCycle();
      checkOutput("rst_busy_before", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async_outputs", 32'({load_weights, start, acc_valid_data_nn_in1, acc_valid_data_nn_in2,
                  busy, done, timeout_err, pass_cnt}), 32'd0);
      #13;
      rst = 1'b0;
      stepCycle();
      checkOutput("rst_idle_busy", 32'(busy), 32'd0);
      applyStimulus(4'd1, 16'h0321, 16'h0123, 1'b1);
      waitStart(10);
      respond(1, 2, 0);
      checkOutput("rst_rerun_done", 32'(done), 32'd1);
      stepCycle();

      checkOutput("nn_queue_empty", 32'(nnQ.size()), 32'd0);
      checkOutput("done_queue_empty", 32'(doneQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
